// File: rtl/wb_vmon_pkg.sv
// rtl/wb_vmon_pkg.sv - SEL patterns, size codes and message type for the vmon write monitor
package wb_vmon_pkg;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    localparam logic [2:0] SZ_1 = 3'd1;
    localparam logic [2:0] SZ_2 = 3'd2;
    localparam logic [2:0] SZ_4 = 3'd4;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  size;
    } vmon_msg_t;

endpackage

// File: rtl/wb_vmon_write_monitor_sel_decode.sv
// rtl/wb_vmon_write_monitor_sel_decode.sv - packs byte-lane-selected write data down to byte 0
module wb_vmon_sel_decode
    import wb_vmon_pkg::*;
(
    input  logic [3:0]  sel,
    input  logic [31:0] dat,
    output vmon_msg_t   msg,
    output logic        unsupported
);

    always_comb begin
        msg         = '0;
        unsupported = 1'b0;
        case (sel)
            SEL_B0: begin msg.data = {24'h0, dat[7:0]};   msg.size = SZ_1; end
            SEL_B1: begin msg.data = {24'h0, dat[15:8]};  msg.size = SZ_1; end
            SEL_B2: begin msg.data = {24'h0, dat[23:16]}; msg.size = SZ_1; end
            SEL_B3: begin msg.data = {24'h0, dat[31:24]}; msg.size = SZ_1; end
            SEL_H0: begin msg.data = {16'h0, dat[15:0]};  msg.size = SZ_2; end
            SEL_H1: begin msg.data = {16'h0, dat[31:16]}; msg.size = SZ_2; end
            SEL_W:  begin msg.data = dat;                 msg.size = SZ_4; end
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_vmon_write_monitor.sv
// rtl/wb_vmon_write_monitor.sv - passive Wishbone tap turning mailbox writes into vmon messages
module wb_vmon_write_monitor
    import wb_vmon_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    input  logic                       CYC,
    input  logic                       ERR,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       STB,
    input  logic                       ACK,
    input  logic                       WE,
    output logic                       msg_valid,
    output logic [31:0]                msg_data,
    output logic [2:0]                 msg_size,
    output logic                       sel_err,
    output logic [31:0]                msg_count
);

    localparam int LSB = $clog2(WB_DATA_WIDTH) - 1;

    generate
        if (WB_DATA_WIDTH != 32) begin : g_bad_width
            $error("wb_vmon_write_monitor supports WB_DATA_WIDTH=32 only");
        end
    endgenerate

    logic        addr_eq;
    logic        hit;
    vmon_msg_t   dec_msg;
    logic        dec_unsupported;
    logic [31:0] merged_data;
    logic        unused_inputs;

    // ERR is deliberately ignored: only ACK-terminated writes count
    assign unused_inputs = ^{ERR, ADR[LSB-1:0]};

    assign addr_eq = (ADR[WB_ADDR_WIDTH-1:LSB] == ADDRESS[WB_ADDR_WIDTH-1:LSB]);
    assign hit     = CYC & STB & ACK & WE & addr_eq;

    wb_vmon_sel_decode u_sel_decode (
        .sel         (SEL),
        .dat         (DAT_W),
        .msg         (dec_msg),
        .unsupported (dec_unsupported)
    );

    // Bytes beyond the message size keep whatever the register held before
    always_comb begin
        merged_data = msg_data;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(dec_msg.size)) begin
                merged_data[8*b +: 8] = dec_msg.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msg_valid <= 1'b0;
            sel_err   <= 1'b0;
            msg_data  <= '0;
            msg_size  <= '0;
            msg_count <= '0;
        end else begin
            msg_valid <= hit & ~dec_unsupported;
            sel_err   <= hit & dec_unsupported;
            if (hit && !dec_unsupported) begin
                msg_data  <= merged_data;
                msg_size  <= dec_msg.size;
                msg_count <= msg_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_vmon_write_monitor.sv
// tb/tb_wb_vmon_write_monitor.sv - table-driven bench for the vmon write monitor
module tb_wb_vmon_write_monitor;

    localparam logic [31:0] A = 32'h0000_1230;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic        CYC, ERR, STB, ACK, WE;
    logic [3:0]  SEL;
    logic        msg_valid, sel_err;
    logic [31:0] msg_data, msg_count;
    logic [2:0]  msg_size;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_vmon_write_monitor #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .ADDRESS       (A)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ADR       (ADR),
        .DAT_W     (DAT_W),
        .CYC       (CYC),
        .ERR       (ERR),
        .SEL       (SEL),
        .STB       (STB),
        .ACK       (ACK),
        .WE        (WE),
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_size  (msg_size),
        .sel_err   (sel_err),
        .msg_count (msg_count)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        cyc, stb, ack, we, err;
        logic        e_valid, e_sel_err;
        logic [31:0] e_data;
        logic [2:0]  e_size;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic cyc, input logic stb, input logic ack, input logic we,
                       input logic err, input logic ev, input logic ese,
                       input logic [31:0] ed, input logic [2:0] es, input logic [31:0] ec);
        vec_t v;
        v.adr = adr; v.dat = dat; v.sel = sel;
        v.cyc = cyc; v.stb = stb; v.ack = ack; v.we = we; v.err = err;
        v.e_valid = ev; v.e_sel_err = ese; v.e_data = ed; v.e_size = es; v.e_count = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic cyc, input logic stb, input logic ack, input logic we,
                         input logic err);
        ADR = adr; DAT_W = dat; SEL = sel;
        CYC = cyc; STB = stb; ACK = ack; WE = we; ERR = err;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic ese,
                             input logic [31:0] ed, input logic [2:0] es, input logic [31:0] ec);
        chk({tag, " valid"},   {31'h0, msg_valid}, {31'h0, ev});
        chk({tag, " sel_err"}, {31'h0, sel_err},   {31'h0, ese});
        chk({tag, " data"},    msg_data,           ed);
        chk({tag, " size"},    {29'h0, msg_size},  {29'h0, es});
        chk({tag, " count"},   msg_count,          ec);
    endtask

    initial begin
        //   adr      dat            sel      c  s  a  w  e   ev ese  data           sz  cnt
        add(A,       32'h4433_2211, 4'b1111, 1, 1, 1, 1, 0,  1, 0,  32'h4433_2211, 4,  1);
        add(A,       32'hAABB_CCDD, 4'b0100, 1, 1, 1, 1, 0,  1, 0,  32'h4433_22BB, 1,  2);
        add(A,       32'h1234_5678, 4'b1100, 1, 1, 1, 1, 0,  1, 0,  32'h4433_1234, 2,  3);
        add(A,       32'hFFFF_FFFF, 4'b1111, 1, 1, 1, 0, 0,  0, 0,  32'h4433_1234, 2,  3);
        add(A,       32'hFFFF_FFFF, 4'b1111, 1, 1, 0, 1, 0,  0, 0,  32'h4433_1234, 2,  3);
        add(A + 16,  32'hFFFF_FFFF, 4'b1111, 1, 1, 1, 1, 0,  0, 0,  32'h4433_1234, 2,  3);
        add(A,       32'hFFFF_FFFF, 4'b1111, 1, 1, 0, 1, 1,  0, 0,  32'h4433_1234, 2,  3);
        add(A,       32'hFFFF_FFFF, 4'b1111, 0, 1, 1, 1, 0,  0, 0,  32'h4433_1234, 2,  3);
        add(A + 4,   32'h0000_00EE, 4'b0001, 1, 1, 1, 1, 0,  1, 0,  32'h4433_12EE, 1,  4);
        add(A,       32'h5555_5555, 4'b0101, 1, 1, 1, 1, 0,  0, 1,  32'h4433_12EE, 1,  4);
        add(A,       32'h5555_5555, 4'b0000, 1, 1, 1, 1, 0,  0, 1,  32'h4433_12EE, 1,  4);
        add(A,       32'h0000_AB00, 4'b0010, 1, 1, 1, 1, 0,  1, 0,  32'h4433_12AB, 1,  5);
        add(A,       32'h9900_0000, 4'b1000, 1, 1, 1, 1, 0,  1, 0,  32'h4433_1299, 1,  6);
        add(A,       32'h0000_BEEF, 4'b0011, 1, 1, 1, 1, 0,  1, 0,  32'h4433_BEEF, 2,  7);
        add(A,       32'h7777_7777, 4'b0111, 1, 1, 1, 1, 0,  0, 1,  32'h4433_BEEF, 2,  7);
        add(A + 12,  32'hCAFE_F00D, 4'b1111, 1, 1, 1, 1, 0,  1, 0,  32'hCAFE_F00D, 4,  8);
        add(A,       32'h0000_0000, 4'b0000, 0, 0, 0, 0, 0,  0, 0,  32'hCAFE_F00D, 4,  8);

        rst_i = 1'b1;
        drive('0, '0, '0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 check_all("reset", 0, 0, 32'h0, 3'd0, 32'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1 check_all("idle", 0, 0, 32'h0, 3'd0, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].cyc, vecs[i].stb,
                  vecs[i].ack, vecs[i].we, vecs[i].err);
            @(posedge clk_i);
            #1 check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sel_err,
                         vecs[i].e_data, vecs[i].e_size, vecs[i].e_count);
        end

        // Back-to-back hits from a fresh reset
        @(negedge clk_i);
        rst_i = 1'b1;
        drive('0, '0, '0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(A, {4{k[7:0]}}, 4'b1111, 1, 1, 1, 1, 0);
            @(posedge clk_i);
            #1 check_all($sformatf("b2b%0d", k), 1, 0, {4{k[7:0]}}, 3'd4, k);
            @(negedge clk_i);
        end

        // Reset coinciding with a hit suppresses it
        rst_i = 1'b1;
        drive(A, 32'h1111_1111, 4'b1111, 1, 1, 1, 1, 0);
        @(posedge clk_i);
        #1 check_all("rst_hit", 0, 0, 32'h0, 3'd0, 32'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        drive('0, '0, '0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1 check_all("post_rst", 0, 0, 32'h0, 3'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
